// File: rtl/comb_sum_mixer_if.sv
// comb_sum_mixer_if: sample-strobe, operand and mixed-output signals of the comb sum mixer
`ifndef FIXED_POINT
`define FIXED_POINT 16
`endif
interface comb_sum_mixer_if #(
   parameter int WIDTH   = 24,
   parameter int N_COMBS = 4
);
   localparam int WORD = WIDTH + `FIXED_POINT;
   logic                      sample_clk;
   logic signed [WORD-1:0]    dry_in;
   logic [N_COMBS*WORD-1:0]   comb_in;
   logic signed [WORD-1:0]    wet_gain;
   logic signed [WORD-1:0]    dry_gain;
   logic signed [WORD-1:0]    out;
   logic                      out_valid;
   logic                      busy;
   logic                      overrun;
   modport master (
      output sample_clk, dry_in, comb_in, wet_gain, dry_gain,
      input  out, out_valid, busy, overrun
   );
   modport slave (
      input  sample_clk, dry_in, comb_in, wet_gain, dry_gain,
      output out, out_valid, busy, overrun
   );
endinterface

// File: rtl/comb_sum_mixer.sv
// comb_sum_mixer: serially sums the comb bank outputs, applies wet/dry gains and emits a saturated mix per sample
`ifndef FIXED_POINT
`define FIXED_POINT 16
`endif
module comb_sum_mixer #(
   parameter int WIDTH   = 24,
   parameter int N_COMBS = 4
) (
   input logic               clk,
   input logic               rstn,
   comb_sum_mixer_if.slave   bus
);
   localparam int WORD = WIDTH + `FIXED_POINT;
   localparam int CW   = $clog2(N_COMBS);
   localparam int AW   = WORD + CW + 1;
   localparam int PW   = 2 * WORD + CW + 1;
   localparam int IW   = (N_COMBS > 1) ? CW : 1;
   localparam logic signed [PW:0] SMAX = {{(PW - WORD + 2){1'b0}}, {(WORD - 1){1'b1}}};
   localparam logic signed [PW:0] SMIN = {{(PW - WORD + 2){1'b1}}, {(WORD - 1){1'b0}}};
   typedef enum logic [1:0] {IDLE, ACCUM, SCALE, EMIT} state_t;
   state_t                  state, state_n;
   logic                    sclk_q, sclk_rise;
   logic [IW-1:0]           idx;
   logic signed [WORD-1:0]  snap [N_COMBS];
   logic signed [WORD-1:0]  dry_s, wet_g, dry_g;
   logic signed [AW-1:0]    acc;
   logic signed [PW-1:0]    wet_r, dry_r;
   logic signed [PW:0]      mix;
   logic signed [WORD-1:0]  mix_sat;
   assign sclk_rise = bus.sample_clk & ~sclk_q;
   assign mix       = (PW+1)'(wet_r) + (PW+1)'(dry_r);
   assign mix_sat   = mix > SMAX ? WORD'(SMAX) : mix < SMIN ? WORD'(SMIN) : WORD'(mix);
   // state register
   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_n;
   end
   // frame sequencing: start on a strobe edge in IDLE, one comb per clk, then scale and emit
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = sclk_rise ? ACCUM : IDLE;
         ACCUM:   state_n = (idx == IW'(N_COMBS - 1)) ? SCALE : ACCUM;
         SCALE:   state_n = EMIT;
         default: state_n = IDLE;
      endcase
   end
   // datapath: snapshot, serial accumulate, gain products, saturated output and status flags
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sclk_q        <= 1'b1;
         acc           <= '0;
         idx           <= '0;
         bus.out       <= '0;
         bus.out_valid <= 1'b0;
         bus.busy      <= 1'b0;
         bus.overrun   <= 1'b0;
      end else begin
         sclk_q        <= bus.sample_clk;
         bus.out_valid <= 1'b0;
         bus.busy      <= (state_n != IDLE) || (state == EMIT);
         if (sclk_rise && state != IDLE) bus.overrun <= 1'b1;
         if (state == IDLE && sclk_rise) begin
            for (int k = 0; k < N_COMBS; k++) snap[k] <= bus.comb_in[k*WORD +: WORD];
            dry_s <= bus.dry_in;
            wet_g <= bus.wet_gain;
            dry_g <= bus.dry_gain;
            acc   <= '0;
            idx   <= '0;
         end
         if (state == ACCUM) begin
            acc <= acc + AW'(snap[idx]);
            idx <= idx + IW'(1);
         end
         if (state == SCALE) begin
            wet_r <= (PW'(acc) * PW'(wet_g)) >>> `FIXED_POINT;
            dry_r <= (PW'(dry_s) * PW'(dry_g)) >>> `FIXED_POINT;
         end
         if (state == EMIT) begin
            bus.out       <= mix_sat;
            bus.out_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_comb_sum_mixer.sv
// tb_comb_sum_mixer: directed vector table plus overrun, reset and strobe-level sequences
`ifndef FIXED_POINT
`define FIXED_POINT 16
`endif
module tb_comb_sum_mixer;
   localparam int     WIDTH   = 24;
   localparam int     N_COMBS = 4;
   localparam int     WORD    = WIDTH + `FIXED_POINT;
   localparam longint ONE     = 64'sd1 <<< `FIXED_POINT;
   localparam longint MAXV    = (64'sd1 <<< (WORD - 1)) - 1;
   localparam longint MINV    = -(64'sd1 <<< (WORD - 1));
   typedef struct {
      longint c0, c1, c2, c3, dry, wg, dg, exp;
   } vec_t;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int n_checks = 0;
   int n_fail = 0;
   vec_t vecs [7];
   comb_sum_mixer_if #(.WIDTH(WIDTH), .N_COMBS(N_COMBS)) bus ();
   comb_sum_mixer #(.WIDTH(WIDTH), .N_COMBS(N_COMBS)) dut (.clk(clk), .rstn(rstn), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string name, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask
   task automatic drive(input longint c0, c1, c2, c3, d, wg, dg);
      bus.comb_in  = {WORD'(c3), WORD'(c2), WORD'(c1), WORD'(c0)};
      bus.dry_in   = WORD'(d);
      bus.wet_gain = WORD'(wg);
      bus.dry_gain = WORD'(dg);
   endtask
   task automatic run_frame(input longint c0, c1, c2, c3, d, wg, dg, input bit second,
                            output longint got, output int lat, output int pulses,
                            output bit busy_mid, output bit busy_after);
      @(negedge clk);
      drive(c0, c1, c2, c3, d, wg, dg);
      bus.sample_clk = 1'b1;
      @(negedge clk);
      bus.sample_clk = 1'b0;
      drive(7 * ONE, 7 * ONE, 7 * ONE, 7 * ONE, 9 * ONE, ONE, ONE);
      busy_mid   = bus.busy;
      busy_after = 1'b1;
      lat        = -1;
      pulses     = 0;
      got        = 0;
      for (int n = 1; n <= 14; n++) begin
         if (second && n == 2) bus.sample_clk = 1'b1;
         if (second && n == 3) bus.sample_clk = 1'b0;
         @(negedge clk);
         if (bus.out_valid) begin
            pulses++;
            if (lat < 0) begin
               lat = n;
               got = bus.out;
            end
         end
         if (n == N_COMBS + 3) busy_after = bus.busy;
      end
   endtask
   initial begin
      longint got;
      int     lat, pulses;
      bit     bm, ba;
      vecs[0] = '{ONE, 2 * ONE, 3 * ONE, 4 * ONE, 5 * ONE, ONE / 4, 0, 163840};
      vecs[1] = '{MAXV, MAXV, MAXV, MAXV, MAXV, ONE, ONE, MAXV};
      vecs[2] = '{MINV, MINV, MINV, MINV, MINV, ONE, ONE, MINV};
      vecs[3] = '{-1, -1, -1, 0, 0, ONE / 2, 0, -2};
      vecs[4] = '{ONE, ONE, ONE, ONE, 2 * ONE, ONE, ONE / 2, 5 * ONE};
      vecs[5] = '{0, 0, 0, 0, -3, ONE, ONE / 2, -2};
      vecs[6] = '{ONE, ONE, ONE, ONE, ONE, -ONE / 2, -ONE, -3 * ONE};
      bus.sample_clk = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("reset out", bus.out, 0);
      check("reset out_valid", longint'(bus.out_valid), 0);
      check("reset busy", longint'(bus.busy), 0);
      check("reset overrun", longint'(bus.overrun), 0);
      for (int i = 0; i < 7; i++) begin
         run_frame(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3, vecs[i].dry,
                   vecs[i].wg, vecs[i].dg, 1'b0, got, lat, pulses, bm, ba);
         check($sformatf("vec%0d out", i), got, vecs[i].exp);
         check($sformatf("vec%0d latency", i), lat, N_COMBS + 2);
         check($sformatf("vec%0d pulses", i), pulses, 1);
         check($sformatf("vec%0d busy during", i), longint'(bm), 1);
         check($sformatf("vec%0d busy after", i), longint'(ba), 0);
      end
      check("overrun before", longint'(bus.overrun), 0);
      run_frame(vecs[0].c0, vecs[0].c1, vecs[0].c2, vecs[0].c3, vecs[0].dry,
                vecs[0].wg, vecs[0].dg, 1'b1, got, lat, pulses, bm, ba);
      check("overrun out", got, vecs[0].exp);
      check("overrun pulses", pulses, 1);
      check("overrun flag", longint'(bus.overrun), 1);
      repeat (10) @(negedge clk);
      check("overrun sticky", longint'(bus.overrun), 1);
      @(negedge clk);
      drive(ONE, ONE, ONE, ONE, 0, ONE, 0);
      bus.sample_clk = 1'b1;
      @(negedge clk);
      bus.sample_clk = 1'b0;
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      check("mid reset out", bus.out, 0);
      check("mid reset busy", longint'(bus.busy), 0);
      check("mid reset overrun", longint'(bus.overrun), 0);
      pulses = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (bus.out_valid) pulses++;
      end
      check("mid reset no pulse", pulses, 0);
      run_frame(vecs[4].c0, vecs[4].c1, vecs[4].c2, vecs[4].c3, vecs[4].dry,
                vecs[4].wg, vecs[4].dg, 1'b0, got, lat, pulses, bm, ba);
      check("post reset out", got, vecs[4].exp);
      check("post reset pulses", pulses, 1);
      @(negedge clk);
      bus.sample_clk = 1'b1;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      pulses = 0;
      bm = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (bus.out_valid) pulses++;
         if (bus.busy) bm = 1'b1;
      end
      check("held strobe no pulse", pulses, 0);
      check("held strobe no busy", longint'(bm), 0);
      bus.sample_clk = 1'b0;
      run_frame(vecs[6].c0, vecs[6].c1, vecs[6].c2, vecs[6].c3, vecs[6].dry,
                vecs[6].wg, vecs[6].dg, 1'b0, got, lat, pulses, bm, ba);
      check("strobe retrigger out", got, vecs[6].exp);
      check("strobe retrigger pulses", pulses, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
